// File: rtl/count_sequencer_if.sv
// Command/status bundle between a run master and the count sequencer.
interface count_sequencer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             up;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] t_en;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, stop, pause, up, limit,
        input  count, t_en, busy, done, state
    );

    modport slave (
        input  start, stop, pause, up, limit,
        output count, t_en, busy, done, state
    );
endinterface

// File: rtl/count_sequencer.sv
// Run controller for the toggle-flip-flop counter: steps a count register
// toward a latched terminal value and publishes the per-edge toggle mask.
module count_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    count_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] t_en_q;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] step_val;
    logic             at_target;

    // Terminal value and one-step neighbour for the latched direction.
    always_comb begin
        target    = dir_q ? lim_q : '0;
        step_val  = dir_q ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        at_target = (count_q == target);
    end

    // Next-state, next-count and registered-status decode.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lim_d   = lim_q;
        dir_d   = dir_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    lim_d   = bus.limit;
                    dir_d   = bus.up;
                    count_d = bus.up ? '0 : bus.limit;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (bus.pause) begin
                    state_d = S_PAUSE;
                end else if (at_target) begin
                    state_d = S_DONE;
                end else begin
                    count_d = step_val;
                end
            end
            S_PAUSE: begin
                // The resume edge acts as a RUN edge, so each paused cycle
                // costs exactly one extra edge.
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (!bus.pause) begin
                    if (at_target) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        count_d = step_val;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            t_en_q  <= '0;
            lim_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            t_en_q  <= count_q ^ count_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.t_en  = t_en_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_count_sequencer.sv
// Vector-table bench for count_sequencer with a scoreboard queue.
module tb_count_sequencer;
    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] RN = 2'b01;
    localparam logic [1:0] PS = 2'b10;
    localparam logic [1:0] DN = 2'b11;

    typedef struct {
        logic       s;
        logic       sp;
        logic       p;
        logic       u;
        logic [3:0] l;
        logic [3:0] c;
        logic [3:0] t;
        logic       b;
        logic       d;
        logic [1:0] st;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   vidx = 0;

    vec_t tbl[$];
    vec_t sb[$];

    count_sequencer_if #(.WIDTH(4)) bus ();

    count_sequencer #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(logic s, logic sp, logic p, logic u, logic [3:0] l,
                               logic [3:0] c, logic [3:0] t, logic b, logic d,
                               logic [1:0] st);
        vec_t r;
        r.s = s; r.sp = sp; r.p = p; r.u = u; r.l = l;
        r.c = c; r.t = t; r.b = b; r.d = d; r.st = st;
        return r;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got %0h expected %0h", name, vidx, act, exp);
        end
    endtask

    task automatic compare_outputs(input vec_t e);
        check("count", bus.count, e.c);
        check("t_en", bus.t_en, e.t);
        check("busy", 4'(bus.busy), 4'(e.b));
        check("done", 4'(bus.done), 4'(e.d));
        check("state", 4'(bus.state), 4'(e.st));
    endtask

    // Drive one vector for one edge; expectation travels through the scoreboard.
    task automatic apply(input vec_t x);
        vec_t e;
        @(negedge clk);
        bus.start = x.s; bus.stop = x.sp; bus.pause = x.p;
        bus.up = x.u; bus.limit = x.l;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty (vector %0d)", vidx);
        end else begin
            e = sb.pop_front();
            compare_outputs(e);
        end
        vidx++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] kk;
        logic [3:0] zero4;
        vec_t rv;
        zero4 = '0;

        // Up run, limit 5
        tbl.push_back(v(1,0,0,1,5, 0,0,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 1,1,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 2,3,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 3,1,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 4,7,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 5,1,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 5,0,0,1,DN));
        tbl.push_back(v(0,0,0,0,0, 5,0,0,0,ID));
        // Down run, limit 3, with ignored start/limit/up change mid-run
        tbl.push_back(v(1,0,0,0,3, 3,6,1,0,RN));
        tbl.push_back(v(1,0,0,1,9, 2,1,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 1,3,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 0,1,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,1,DN));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,0,ID));
        // Up run, limit 9, paused three cycles at count 4
        tbl.push_back(v(1,0,0,1,9, 0,0,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 1,1,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 2,3,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 3,1,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 4,7,1,0,RN));
        tbl.push_back(v(0,0,1,0,0, 4,0,1,0,PS));
        tbl.push_back(v(0,0,1,0,0, 4,0,1,0,PS));
        tbl.push_back(v(0,0,1,0,0, 4,0,1,0,PS));
        tbl.push_back(v(0,0,0,0,0, 5,1,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 6,3,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 7,1,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 8,15,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 9,1,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 9,0,0,1,DN));
        tbl.push_back(v(0,0,0,0,0, 9,0,0,0,ID));
        // Stop at count 6
        tbl.push_back(v(1,0,0,1,9, 0,9,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 1,1,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 2,3,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 3,1,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 4,7,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 5,1,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 6,3,1,0,RN));
        tbl.push_back(v(0,1,0,0,0, 6,0,0,0,ID));
        tbl.push_back(v(0,1,1,0,0, 6,0,0,0,ID));
        // Stop and pause together
        tbl.push_back(v(1,0,0,1,9, 0,6,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 1,1,1,0,RN));
        tbl.push_back(v(0,1,1,0,0, 1,0,0,0,ID));
        tbl.push_back(v(0,0,1,0,0, 1,0,0,0,ID));
        // Limit 0
        tbl.push_back(v(1,0,0,1,0, 0,1,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,1,DN));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,0,ID));
        // Limit 15 up, start pulsed while busy at count 3
        tbl.push_back(v(1,0,0,1,15, 0,0,1,0,RN));
        for (int k = 1; k <= 15; k++) begin
            kk = 4'(k);
            tbl.push_back(v(k == 3, 0, 0, 0, (k == 3) ? 4'd2 : 4'd0,
                            kk, kk ^ (kk - 4'd1), 1, 0, RN));
        end
        tbl.push_back(v(0,0,0,0,0, 15,0,0,1,DN));
        tbl.push_back(v(0,0,0,0,0, 15,0,0,0,ID));
        // Pause coinciding with terminal count (down, limit 2)
        tbl.push_back(v(1,0,0,0,2, 2,13,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 1,3,1,0,RN));
        tbl.push_back(v(0,0,0,0,0, 0,1,1,0,RN));
        tbl.push_back(v(0,0,1,0,0, 0,0,1,0,PS));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,1,DN));
        tbl.push_back(v(0,0,0,0,0, 0,0,0,0,ID));
        // Stop while paused
        tbl.push_back(v(1,0,0,1,3, 0,0,1,0,RN));
        tbl.push_back(v(0,0,1,0,0, 0,0,1,0,PS));
        tbl.push_back(v(0,1,1,0,0, 0,0,0,0,ID));

        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.up = 0; bus.limit = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rv = v(0,0,0,0,0, 0,0,0,0,ID);
        compare_outputs(rv);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Asynchronous reset mid-run at count 5
        apply(v(1,0,0,1,9, 0,0,1,0,RN));
        apply(v(0,0,0,0,0, 1,1,1,0,RN));
        apply(v(0,0,0,0,0, 2,3,1,0,RN));
        apply(v(0,0,0,0,0, 3,1,1,0,RN));
        apply(v(0,0,0,0,0, 4,7,1,0,RN));
        apply(v(0,0,0,0,0, 5,1,1,0,RN));
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", bus.count, zero4);
        check("async_rst_t_en", bus.t_en, zero4);
        check("async_rst_busy", 4'(bus.busy), zero4);
        check("async_rst_done", 4'(bus.done), zero4);
        check("async_rst_state", 4'(bus.state), zero4);
        @(posedge clk);
        #1;
        rv = v(0,0,0,0,0, 0,0,0,0,ID);
        compare_outputs(rv);
        @(negedge clk);
        rst_n = 1'b1;
        apply(v(0,0,0,0,0, 0,0,0,0,ID));
        apply(v(0,0,0,0,0, 0,0,0,0,ID));
        apply(v(1,0,0,1,1, 0,0,1,0,RN));
        apply(v(0,0,0,0,0, 1,1,1,0,RN));
        apply(v(0,0,0,0,0, 1,0,0,1,DN));
        apply(v(0,0,0,0,0, 1,0,0,0,ID));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_sequencer.md
# count_sequencer

Run controller for the toggle-flip-flop counter datapath. It accepts a start command with a terminal value and a direction, then steps a WIDTH-bit count register one position per clock. Counting can be paused, aborted or left to finish. Each cycle it also publishes the per-stage toggle mask, so the T-stage counter bank and its checkers see exactly which stages flipped.

## Interface
Parameters:
- WIDTH, 4, count and limit width in bits (≥ 2)

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- start  input  1  begin a run; sampled only in IDLE
- stop  input  1  abort current run; highest priority after reset
- pause  input  1  freeze count while high (RUN/PAUSE only)
- up  input  1  direction, latched at start: 1 = count up, 0 = count down
- limit  input  WIDTH  terminal value, latched at start
- count  output  WIDTH  current count (registered)
- t_en  output  WIDTH  toggle mask of the last edge: bits of count that changed (registered)
- busy  output  1  high in RUN or PAUSE
- done  output  1  one-cycle pulse, high in DONE only
- state  output  2  IDLE = 00, RUN = 01, PAUSE = 10, DONE = 11

## Operation
- Reset (rst = 0, any time, mid-run included) forces the following immediately, without waiting for clk:
  - state = IDLE
  - count = 0, t_en = 0, busy = 0, done = 0
  - latched limit/direction = 0
- IDLE:
  - count holds.
  - On start = 1: latch limit into lim_q and up into dir_q.
  - Load count with 0 (up) or limit (down); go to RUN.
  - stop and pause are ignored in IDLE.
- RUN (priority order, evaluated each edge):
  1. stop = 1: go to IDLE, count holds.
  2. pause = 1: go to PAUSE, count holds.
  3. count == target (target = lim_q if up, 0 if down): go to DONE, count holds.
  4. Otherwise count +1 (up) or −1 (down).
- PAUSE:
  - stop = 1: go to IDLE.
  - pause = 0: go to RUN.
  - Otherwise stay in PAUSE; count holds.
- DONE: unconditionally go to IDLE next edge; count holds at target.
- start is ignored in every state except IDLE; a new run is never latched while busy or done is high.
- Changes to limit or up mid-run have no effect.
- Arithmetic:
  - Count stays within the range 0..lim_q, so no wrap-around occurs.
  - limit = 2^WIDTH−1 counts up to all-ones and stops.
  - limit = 0 produces count 0 followed directly by DONE.
- t_en:
  - On every edge, t_en ← count_old XOR count_new.
  - t_en is 0 on any edge where count holds.
  - On the start edge, t_en = previous count XOR the load value.
- Count holds at the final value after DONE/stop until the next start.

## Timing
- Call the edge where start is sampled in IDLE E0.
- Up run with limit = L:
  - count = 0 after E0 and count = k after E0+k.
  - count reaches L after E0+L.
  - state = DONE (done = 1) after E0+L+1.
  - state = IDLE after E0+L+2.
  - Total: L+2 edges.
- Down run: count = L after E0 and count = L−k after E0+k; the same L+2 edge total applies.
- Each pause cycle adds exactly one edge.
- stop sampled in RUN or PAUSE: IDLE on that edge, no done pulse.
- stop and pause high on the same edge: stop wins.
- pause and the terminal condition on the same edge: pause wins; DONE follows on the first non-paused RUN edge.
- busy and done are never high together; done is high for exactly one cycle per completed run.
- rst deassertion is treated as synchronous to clk by the integrator; the first possible start sample is the first rising edge with rst = 1.

## Test plan
- Reset, then up run: WIDTH = 4, start with up = 1, limit = 5.
  - count sequence 0,1,2,3,4,5,5(DONE),5(IDLE).
  - done high exactly one cycle at edge E0+6.
  - t_en after E0+4 = 0111 (3→4).
- Down run: up = 0, limit = 3.
  - count 3,2,1,0, then DONE, then IDLE.
  - busy high for edges E0..E0+3.
  - t_en at 1→0 = 0001.
- Pause and stop:
  - Up run with limit = 9; pause high for 3 cycles at count = 4. count holds at 4 for 3 cycles; done arrives at E0+13.
  - Repeat, but assert stop at count = 6: IDLE next edge, count stays 6, no done pulse.
  - Assert stop and pause on the same edge: IDLE.
- Boundaries:
  - limit = 0: DONE after E0+1, IDLE after E0+2.
  - limit = 15 up: reaches 1111 with no wrap; t_en at 7→8 = 1111.
  - start pulsed while busy: no change to count, lim_q or dir_q.
- Asynchronous reset mid-run: drop rst between edges at count = 5. count, t_en, busy and done go to 0 and state to 00 before the next edge, then remain at those values until the next start.
